dw_mode_ctrl: RTL and testbench
===============================

// Module: dw_mode_ctrl
// PURPOSE
// - User-interface sequencer for the digital watch: debounces the mode/set buttons, walks the mode FSM and
//   issues 1-cycle increment/control strobes to the timekeeping, alarm and stopwatch datapaths.
// - Sits between the top-level mode/set pins and the watch core; also drives display select and edit-blink.
// PARAMETERS
// - DEBOUNCE_CYCLES  20'd500000  clk cycles a raw button level must be stable before it is accepted (>=1)
// - TIMEOUT_S        8'd30       tick_1hz pulses of inactivity in an edit mode before auto-return to TIME (>=1)
// - HOLD_S           8'd2        tick_1hz pulses set must stay held before auto-repeat starts (DW_AUTOREPEAT_EN only)
// PORTS
// - clk           in   1  system clock, single clock domain
// - rst           in   1  synchronous, active-high reset
// - mode          in   1  raw mode button, already synchronised to clk, active-high
// - set           in   1  raw set button, already synchronised to clk, active-high
// - tick_1hz      in   1  1-cycle pulse once per second from the timebase
// - mode_state    out  3  0 TIME, 1 SET_HR, 2 SET_MIN, 3 ALM_HR, 4 ALM_MIN, 5 STOPWATCH
// - inc_hours     out  1  1-cycle strobe: time hours +1 (datapath wraps 23->0)
// - inc_minutes   out  1  1-cycle strobe: time minutes +1 (datapath wraps 59->0, no hour carry)
// - alm_inc_hours out  1  1-cycle strobe: alarm hours +1
// - alm_inc_min   out  1  1-cycle strobe: alarm minutes +1
// - alarm_en      out  1  alarm arm level
// - sw_run        out  1  stopwatch run level
// - sw_clear      out  1  1-cycle strobe: clear stopwatch to 00:00
// - blink         out  1  edited-field blank enable for the display
// BEHAVIOUR
// - Reset: mode_state=TIME, all strobes 0, alarm_en=0, sw_run=0, blink=0, debounced levels=0, counters=0.
// - Debounce per button: counter clears whenever raw==debounced; when raw!=debounced for DEBOUNCE_CYCLES
//   consecutive cycles, debounced<=raw. Press = debounced 0->1; acted on in the NEXT cycle (strobes
//   registered). Glitch shorter than DEBOUNCE_CYCLES -> no effect. Release edges are never acted on.
// - Mode press: TIME->SET_HR->SET_MIN->ALM_HR->ALM_MIN->STOPWATCH->TIME. Strobes never fire on a mode step.
// - Set press: TIME toggles alarm_en; SET_HR inc_hours; SET_MIN inc_minutes; ALM_HR alm_inc_hours;
//   ALM_MIN alm_inc_min; STOPWATCH toggles sw_run.
// - Same-cycle mode+set press: in STOPWATCH -> sw_clear strobe, sw_run<=0, state unchanged;
//   in any other state mode wins, set is dropped.
// - sw_run persists after leaving STOPWATCH (stopwatch keeps running in background).
// - Timeout: 8-bit idle counter counts tick_1hz only in states 1-4; cleared by any accepted press and
//   on every state change; reaching TIMEOUT_S -> state TIME next cycle, counter cleared, no strobe.
// - blink toggles on each tick_1hz in states 1-4; forced 0 in TIME/STOPWATCH and on every state change.
// - Strobes are mutually exclusive and exactly 1 cycle; at most one per accepted press.
// - rst mid-operation (incl. mid-debounce or mid-hold) returns everything to reset values next edge;
//   a button still held through reset must be released and re-pressed to act.
// CONFIGURATION
// - DW_AUTOREPEAT_EN defined: in states 1-4, set held (debounced 1) for HOLD_S tick_1hz pulses starts
//   auto-repeat; thereafter one strobe of the state's increment type per tick_1hz until release; each
//   repeat strobe also clears the idle counter. Hold counter clears on release, mode press or state change.
// - DW_AUTOREPEAT_EN undefined: hold logic absent; holding set yields exactly one strobe per press.
// TESTING (bench uses DEBOUNCE_CYCLES=4, TIMEOUT_S=5, HOLD_S=2)
// - Reset then 6 clean mode presses (8-cycle highs/lows) -> mode_state 1,2,3,4,5,0; no strobes; blink=0 in 0/5.
// - 3-cycle set glitch in SET_HR -> no inc_hours; 4-cycle-stable press -> exactly one inc_hours, 1 cycle wide,
//   asserted 1 cycle after debounced rise.
// - In SET_MIN, no presses for 5 tick_1hz -> mode_state=0 cycle after 5th tick; blink toggled on ticks 1-4.
// - In STOPWATCH: set -> sw_run=1; mode+set same cycle -> sw_clear one cycle, sw_run=0, state stays 5;
//   set then mode -> state 0 with sw_run=1 held.
// - TIME: set press -> alarm_en 0->1, second press -> 0; mode+set simultaneous in TIME -> state 1, alarm_en unchanged.
// - DW_AUTOREPEAT_EN: hold set in ALM_HR for 6 ticks -> 1 press strobe + alm_inc_hours on ticks 3..6
//   (4 repeats), no timeout; without macro -> exactly 1 strobe. rst asserted mid-hold -> all outputs reset.

Source files
------------

// File: rtl/dw_mode_ctrl.sv
// dw_mode_ctrl: watch UI sequencer, button debounce, mode FSM, datapath strobes.
// Define DW_AUTOREPEAT_EN to add set-button auto-repeat in the edit modes.
module dw_mode_ctrl #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000,
  parameter logic [7:0]  TIMEOUT_S       = 8'd30,
  parameter logic [7:0]  HOLD_S          = 8'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       set,
  input  logic       tick_1hz,
  output logic [2:0] mode_state,
  output logic       inc_hours,
  output logic       inc_minutes,
  output logic       alm_inc_hours,
  output logic       alm_inc_min,
  output logic       alarm_en,
  output logic       sw_run,
  output logic       sw_clear,
  output logic       blink
);

  typedef enum logic [2:0] {
    ST_TIME    = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_ALM_HR  = 3'd3,
    ST_ALM_MIN = 3'd4,
    ST_SW      = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      raw;
  logic [1:0]      db_q, db_d;
  logic [1:0]      prev_q;
  logic [1:0]      lock_q, lock_d;
  logic [1:0][19:0] cnt_q, cnt_d;
  logic [1:0]      press;
  logic            mode_p, set_p;
  logic [4:0]      stb_q, stb_d;
  logic            alarm_q, alarm_d;
  logic            run_q, run_d;
  logic [7:0]      idle_q, idle_d;
  logic            blink_q, blink_d;
  logic            edit;
  logic            timeout;
  logic            rep;

  assign raw     = {set, mode};
  // lock_q masks presses from a button still held when reset ended
  assign press   = db_q & ~prev_q & ~lock_q;
  assign mode_p  = press[0];
  assign set_p   = press[1];
  assign edit    = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN) ||
                   (state_q == ST_ALM_HR) || (state_q == ST_ALM_MIN);
  assign timeout = edit && (idle_q >= TIMEOUT_S);

  function automatic state_e next_mode(input state_e s);
    unique case (s)
      ST_TIME:    next_mode = ST_SET_HR;
      ST_SET_HR:  next_mode = ST_SET_MIN;
      ST_SET_MIN: next_mode = ST_ALM_HR;
      ST_ALM_HR:  next_mode = ST_ALM_MIN;
      ST_ALM_MIN: next_mode = ST_SW;
      default:    next_mode = ST_TIME;
    endcase
  endfunction

  // strobe bit order: {inc_hours, inc_minutes, alm_inc_hours, alm_inc_min, sw_clear}
  function automatic logic [4:0] inc_stb(input state_e s);
    unique case (s)
      ST_SET_HR:  inc_stb = 5'b10000;
      ST_SET_MIN: inc_stb = 5'b01000;
      ST_ALM_HR:  inc_stb = 5'b00100;
      ST_ALM_MIN: inc_stb = 5'b00010;
      default:    inc_stb = 5'b00000;
    endcase
  endfunction

  // per-button debounce: accept a new level after it differs long enough
  always_comb begin
    db_d   = db_q;
    cnt_d  = '0;
    lock_d = lock_q & raw;
    for (int i = 0; i < 2; i++) begin
      if (raw[i] != db_q[i]) begin
        if (cnt_q[i] == DEBOUNCE_CYCLES - 20'd1) begin
          db_d[i] = raw[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 20'd1;
        end
      end
    end
  end

`ifdef DW_AUTOREPEAT_EN
  logic [7:0] hold_q, hold_d;

  // count held-set ticks; once past HOLD_S every tick repeats the increment
  always_comb begin
    hold_d = hold_q;
    rep    = 1'b0;
    if (!db_q[1] || mode_p || !edit || timeout) begin
      hold_d = '0;
    end else if (tick_1hz) begin
      if (hold_q >= HOLD_S) begin
        rep = !set_p;
      end else begin
        hold_d = hold_q + 8'd1;
      end
    end
  end

  // hold counter register
  always_ff @(posedge clk) begin
    if (rst) hold_q <= '0;
    else     hold_q <= hold_d;
  end
`else
  logic unused_hold;
  assign unused_hold = ^HOLD_S;
  assign rep         = 1'b0;
`endif

  // mode FSM next state, strobes, levels, idle timer and blink
  always_comb begin
    state_d = state_q;
    stb_d   = '0;
    alarm_d = alarm_q;
    run_d   = run_q;
    idle_d  = idle_q;
    blink_d = blink_q;
    if (timeout) begin
      state_d = ST_TIME;
    end else if (mode_p && set_p && state_q == ST_SW) begin
      stb_d[0] = 1'b1;
      run_d    = 1'b0;
    end else if (mode_p) begin
      state_d = next_mode(state_q);
    end else if (set_p) begin
      if (state_q == ST_TIME)    alarm_d = ~alarm_q;
      else if (state_q == ST_SW) run_d   = ~run_q;
      else                       stb_d   = inc_stb(state_q);
    end else if (rep) begin
      stb_d = inc_stb(state_q);
    end
    if (state_d != state_q || mode_p || set_p || rep) begin
      idle_d = '0;
    end else if (edit && tick_1hz) begin
      idle_d = idle_q + 8'd1;
    end
    if (state_d != state_q || !edit) begin
      blink_d = 1'b0;
    end else if (tick_1hz) begin
      blink_d = ~blink_q;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_TIME;
      db_q    <= '0;
      prev_q  <= '0;
      lock_q  <= 2'b11;
      cnt_q   <= '0;
      stb_q   <= '0;
      alarm_q <= 1'b0;
      run_q   <= 1'b0;
      idle_q  <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      prev_q  <= db_q;
      lock_q  <= lock_d;
      cnt_q   <= cnt_d;
      stb_q   <= stb_d;
      alarm_q <= alarm_d;
      run_q   <= run_d;
      idle_q  <= idle_d;
      blink_q <= blink_d;
    end
  end

  assign mode_state    = state_q;
  assign inc_hours     = stb_q[4];
  assign inc_minutes   = stb_q[3];
  assign alm_inc_hours = stb_q[2];
  assign alm_inc_min   = stb_q[1];
  assign sw_clear      = stb_q[0];
  assign alarm_en      = alarm_q;
  assign sw_run        = run_q;
  assign blink         = blink_q;

endmodule

// File: tb/tb_dw_mode_ctrl.sv
// tb_dw_mode_ctrl: directed and random button/tick stimulus for dw_mode_ctrl.
// Expected behaviour comes from an operation-level watch model.
module tb_dw_mode_ctrl;
  localparam int DB = 4;
  localparam int TO = 5;
  localparam int HS = 2;
`ifdef DW_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, mode, set, tick_1hz;
  logic [2:0] mode_state;
  logic       inc_hours, inc_minutes, alm_inc_hours, alm_inc_min;
  logic       alarm_en, sw_run, sw_clear, blink;

  int checks = 0;
  int errors = 0;
  int obs[5];
  int expc[5];
  int m_state, m_idle, m_hold;
  bit m_alarm, m_run, m_blink, m_held;
  logic [4:0] prev_s = '0;

  dw_mode_ctrl #(
    .DEBOUNCE_CYCLES(20'd4),
    .TIMEOUT_S(8'd5),
    .HOLD_S(8'd2)
  ) dut (
    .clk(clk), .rst(rst), .mode(mode), .set(set), .tick_1hz(tick_1hz),
    .mode_state(mode_state), .inc_hours(inc_hours),
    .inc_minutes(inc_minutes), .alm_inc_hours(alm_inc_hours),
    .alm_inc_min(alm_inc_min), .alarm_en(alarm_en), .sw_run(sw_run),
    .sw_clear(sw_clear), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // strobe monitor: one-hot, one cycle wide, counted per type
  always @(negedge clk) begin
    logic [4:0] s;
    s = {inc_hours, inc_minutes, alm_inc_hours, alm_inc_min, sw_clear};
    if (s != 5'd0) begin
      check("strobe_onehot", $countones(s), 1);
      check("strobe_width", {27'd0, s & prev_s}, 0);
      for (int i = 0; i < 5; i++) if (s[4-i]) obs[i]++;
    end
    prev_s = s;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic bit is_edit(input int s);
    return s >= 1 && s <= 4;
  endfunction

  task automatic m_reset();
    m_state = 0; m_idle = 0; m_hold = 0;
    m_alarm = 0; m_run = 0; m_blink = 0; m_held = 0;
  endtask

  task automatic m_mode();
    m_state = (m_state + 1) % 6;
    m_idle = 0; m_blink = 0; m_hold = 0;
  endtask

  task automatic m_set();
    if (m_state == 0) m_alarm = !m_alarm;
    else if (m_state == 5) m_run = !m_run;
    else expc[m_state-1]++;
    m_idle = 0;
  endtask

  task automatic m_both();
    if (m_state == 5) begin
      expc[4]++; m_run = 0; m_idle = 0;
    end else begin
      m_mode();
    end
  endtask

  task automatic m_tick();
    if (is_edit(m_state)) begin
      m_blink = !m_blink;
      if (AR && m_held && m_hold >= HS) begin
        expc[m_state-1]++;
        m_idle = 0;
      end else begin
        if (m_held) m_hold++;
        m_idle++;
        if (m_idle == TO) begin
          m_state = 0; m_idle = 0; m_blink = 0; m_hold = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    check("mode_state", {29'd0, mode_state}, m_state);
    check("alarm_en", {31'd0, alarm_en}, {31'd0, m_alarm});
    check("sw_run", {31'd0, sw_run}, {31'd0, m_run});
    check("blink", {31'd0, blink}, {31'd0, m_blink});
    check("n_inc_hours", obs[0], expc[0]);
    check("n_inc_minutes", obs[1], expc[1]);
    check("n_alm_inc_hours", obs[2], expc[2]);
    check("n_alm_inc_min", obs[3], expc[3]);
    check("n_sw_clear", obs[4], expc[4]);
  endtask

  task automatic press(input bit pm, input bit ps);
    mode = pm; set = ps;
    cyc(8);
    mode = 0; set = 0;
    cyc(8);
    if (pm && ps) m_both();
    else if (pm) m_mode();
    else if (ps) m_set();
  endtask

  task automatic set_down();
    set = 1; cyc(8);
    m_set(); m_held = 1; m_hold = 0;
  endtask

  task automatic set_up();
    set = 0; cyc(8);
    m_held = 0; m_hold = 0;
  endtask

  task automatic tick_op();
    tick_1hz = 1; cyc(1);
    tick_1hz = 0; cyc(3);
    m_tick();
  endtask

  task automatic glitch();
    int len;
    len = $urandom_range(1, DB - 1);
    if ($urandom_range(0, 1) == 0) mode = 1; else set = 1;
    cyc(len);
    mode = 0; set = 0;
    cyc(6);
  endtask

  task automatic goto_state(input int s);
    while (m_state != s) press(1, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, {29'd0, mode_state}, 0);
    check({tag, "_strobes"}, {27'd0, inc_hours, inc_minutes,
          alm_inc_hours, alm_inc_min, sw_clear}, 0);
    check({tag, "_alarm"}, {31'd0, alarm_en}, 0);
    check({tag, "_run"}, {31'd0, sw_run}, 0);
    check({tag, "_blink"}, {31'd0, blink}, 0);
  endtask

  initial begin
    int base;
    rst = 1; mode = 0; set = 0; tick_1hz = 0;
    m_reset();
    cyc(3);
    check_reset_outputs("reset");
    rst = 0;
    cyc(2);

    // mode walk through all six states
    for (int k = 1; k <= 6; k++) begin
      press(1, 0);
      check("walk_state", {29'd0, mode_state}, k % 6);
      check_all();
    end

    // glitch then timed press in SET_HR
    press(1, 0);
    set = 1; cyc(DB - 1); set = 0; cyc(6);
    check_all();
    set = 1; cyc(DB);
    check("lat_early", {31'd0, inc_hours}, 0);
    cyc(1);
    check("lat_hit", {31'd0, inc_hours}, 1);
    cyc(1);
    check("lat_after", {31'd0, inc_hours}, 0);
    cyc(2); set = 0; cyc(8);
    m_set();
    check_all();

    // timeout from SET_MIN
    press(1, 0);
    for (int k = 1; k <= 4; k++) begin
      tick_op();
      check("blink_tick", {31'd0, blink}, k % 2);
    end
    tick_1hz = 1; cyc(1); tick_1hz = 0;
    check("to_pre", {29'd0, mode_state}, 2);
    cyc(1);
    check("to_post", {29'd0, mode_state}, 0);
    cyc(2);
    m_tick();
    check_all();

    // stopwatch run/clear/background run
    goto_state(5);
    press(0, 1);
    check("sw_start", {31'd0, sw_run}, 1);
    press(1, 1);
    check("sw_clear_state", {29'd0, mode_state}, 5);
    check("sw_clear_run", {31'd0, sw_run}, 0);
    press(0, 1);
    press(1, 0);
    check("sw_bg_state", {29'd0, mode_state}, 0);
    check("sw_bg_run", {31'd0, sw_run}, 1);
    check_all();

    // alarm toggles and mode-wins in TIME
    press(0, 1);
    check("alarm_on", {31'd0, alarm_en}, 1);
    press(0, 1);
    check("alarm_off", {31'd0, alarm_en}, 0);
    press(1, 1);
    check("both_time_state", {29'd0, mode_state}, 1);
    check("both_time_alarm", {31'd0, alarm_en}, 0);
    check_all();

    // held set in ALM_HR for six ticks
    goto_state(3);
    base = obs[2];
    set_down();
    for (int k = 0; k < 6; k++) tick_op();
    set_up();
    check("hold_strobes", obs[2] - base, AR ? 5 : 1);
    check_all();

    // reset mid-hold with the button kept down afterwards
    goto_state(3);
    set_down();
    for (int k = 0; k < 3; k++) tick_op();
    rst = 1; cyc(2);
    check_reset_outputs("midrst");
    rst = 0;
    m_reset();
    cyc(10);
    tick_op();
    tick_op();
    check_all();
    set = 0; cyc(8);
    press(0, 1);
    check("rearm_alarm", {31'd0, alarm_en}, 1);
    check_all();

    // random operation mix
    for (int n = 0; n < 120; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 2) press(1, 0);
      else if (r <= 4) press(0, 1);
      else if (r == 5) press(1, 1);
      else if (r == 6) glitch();
      else if (r <= 8) tick_op();
      else begin
        set_down();
        repeat ($urandom_range(1, 5)) tick_op();
        set_up();
      end
      cyc($urandom_range(0, 3));
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
